// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and constants for the data-memory arbiter.
//            owner_e is used both for the current bus owner and for the
//            port that most recently held the grant.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    localparam int DMEM_ARB_MAX_BURST_DEFAULT = 4;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port (core / debug-loader) arbiter in front of a single
//            data memory with combinational read data. Grants are decided
//            combinationally from registered {owner, last, cnt} state and the
//            live requests; a port holding the bus keeps it until it stops
//            requesting or, under contention, reaches MAX_BURST grants.
//            Read data is captured into the granted port's rdata register on
//            the grant edge and flagged with a one-cycle rvalid.
// Ports    : clk, rst (async, active-low)
//            c_req/c_we/c_addr/c_wdata/c_mask/c_load_ctrl  - core request
//            d_req/d_we/d_addr/d_wdata/d_mask/d_load_ctrl  - debug request
//            c_gnt, d_gnt                                  - grants
//            c_rvalid/c_rdata, d_rvalid/d_rdata            - read responses
//            mem_wr/mem_addr/mem_wdata/mem_mask/mem_load_ctrl, mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = DMEM_ARB_MAX_BURST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_mask,
    input  logic [2:0]  c_load_ctrl,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mask,
    input  logic [2:0]  d_load_ctrl,

    output logic        c_gnt,
    output logic        d_gnt,

    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    output logic [2:0]  mem_load_ctrl,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] C_BURST_LIMIT = 4'(MAX_BURST);
    localparam logic [3:0] C_CNT_SAT     = 4'hF;

    owner_e     r_owner;
    owner_e     r_last;
    logic [3:0] r_cnt;

    owner_e     w_gnt_owner;

    // ------------------------------------------------------------------------
    // Grant decision and memory-side mux
    // ------------------------------------------------------------------------
    always_comb begin
        c_gnt         = 1'b0;
        d_gnt         = 1'b0;
        w_gnt_owner   = OWN_NONE;

        // Grants are forced low while reset is held, even though the reset
        // state (owner NONE) would otherwise grant a live requester.
        if (rst) begin
            unique case (r_owner)
                OWN_NONE: begin
                    if (c_req && d_req) begin
                        // Contention from idle: alternate away from last owner.
                        if (r_last == OWN_CORE) d_gnt = 1'b1;
                        else                    c_gnt = 1'b1;
                    end else begin
                        c_gnt = c_req;
                        d_gnt = d_req;
                    end
                end
                OWN_CORE: begin
                    if (c_req) begin
                        if (d_req && (r_cnt == C_BURST_LIMIT)) d_gnt = 1'b1;
                        else                                   c_gnt = 1'b1;
                    end else begin
                        d_gnt = d_req;
                    end
                end
                OWN_DBG: begin
                    if (d_req) begin
                        if (c_req && (r_cnt == C_BURST_LIMIT)) c_gnt = 1'b1;
                        else                                   d_gnt = 1'b1;
                    end else begin
                        c_gnt = c_req;
                    end
                end
                default: begin
                    c_gnt = 1'b0;
                    d_gnt = 1'b0;
                end
            endcase
        end

        if (c_gnt)      w_gnt_owner = OWN_CORE;
        else if (d_gnt) w_gnt_owner = OWN_DBG;

        // Core is the default source for the address path when idle.
        if (d_gnt) begin
            mem_addr      = d_addr;
            mem_wdata     = d_wdata;
            mem_mask      = d_mask;
            mem_load_ctrl = d_load_ctrl;
        end else begin
            mem_addr      = c_addr;
            mem_wdata     = c_wdata;
            mem_mask      = c_mask;
            mem_load_ctrl = c_load_ctrl;
        end

        mem_wr = (c_gnt & c_we) | (d_gnt & d_we);
    end

    // ------------------------------------------------------------------------
    // Arbitration state and registered read responses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner  <= OWN_NONE;
            r_last   <= OWN_DBG;
            r_cnt    <= 4'd0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rdata  <= 32'h0;
            d_rdata  <= 32'h0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            d_rvalid <= d_gnt & ~d_we;
            if (c_gnt && !c_we) c_rdata <= mem_rdata;
            if (d_gnt && !d_we) d_rdata <= mem_rdata;

            if (w_gnt_owner != OWN_NONE) begin
                r_owner <= w_gnt_owner;
                r_last  <= w_gnt_owner;
                if (r_owner == w_gnt_owner) begin
                    if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + 4'd1;
                end else begin
                    r_cnt <= 4'd1;
                end
            end else begin
                r_owner <= OWN_NONE;
                r_cnt   <= 4'd0;
            end
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A small byte-masked memory
//            model sits on the memory port; expected values are hand-computed
//            constants in a vector table plus reset corner-case sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [3:0]  c_mask, d_mask;
    logic [2:0]  c_load_ctrl, d_load_ctrl;
    logic        c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_mask;
    logic [2:0]  mem_load_ctrl;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_mask(c_mask), .c_load_ctrl(c_load_ctrl),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mask(d_mask), .d_load_ctrl(d_load_ctrl),
        .c_gnt(c_gnt), .d_gnt(d_gnt),
        .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_load_ctrl(mem_load_ctrl),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word array, byte-masked writes on the grant edge,
    // reinitialised on reset. Word i holds 0x1000_0000+i, except word 4.
    logic [31:0] mem [0:63];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
            mem[4] <= 32'hDEAD_BEEF;
        end else if (mem_wr) begin
            for (int b = 0; b < 4; b++)
                if (mem_mask[b]) mem[mem_addr[7:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        gc, gd, wr;
        logic [31:0] addr;
        logic        cv, dv;
        logic [31:0] crd, drd;
    } vec_t;

    function automatic vec_t mk(
        input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
        input logic gc, input logic gd, input logic wr, input logic [31:0] addr,
        input logic cv, input logic dv, input logic [31:0] crd, input logic [31:0] drd);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.gc = gc; v.gd = gd; v.wr = wr; v.addr = addr;
        v.cv = cv; v.dv = dv; v.crd = crd; v.drd = drd;
        return v;
    endfunction

    vec_t vt [23];

    initial begin
        // Idle / core read / RAW / debug handover / idle
        vt[0]  = mk(0,0,32'h00,0,            0,0,32'h00,0,  0,0,0,32'h00, 0,0,32'h0,32'h0);
        vt[1]  = mk(1,0,32'h10,0,            0,0,32'h00,0,  1,0,0,32'h10, 0,0,32'h0,32'h0);
        vt[2]  = mk(1,1,32'h20,32'hA5A5A5A5, 0,0,32'h00,0,  1,0,1,32'h20, 1,0,32'hDEADBEEF,32'h0);
        vt[3]  = mk(1,0,32'h20,0,            0,0,32'h00,0,  1,0,0,32'h20, 0,0,32'hDEADBEEF,32'h0);
        vt[4]  = mk(0,0,32'h00,0,            0,0,32'h00,0,  0,0,0,32'h00, 1,0,32'hA5A5A5A5,32'h0);
        vt[5]  = mk(0,0,32'h00,0,            1,0,32'h30,0,  0,1,0,32'h30, 0,0,32'hA5A5A5A5,32'h0);
        vt[6]  = mk(1,0,32'h10,0,            0,0,32'h30,0,  1,0,0,32'h10, 0,1,32'hA5A5A5A5,32'h1000000C);
        vt[7]  = mk(0,0,32'h00,0,            0,0,32'h00,0,  0,0,0,32'h00, 1,0,32'hDEADBEEF,32'h1000000C);
        vt[8]  = mk(0,0,32'h00,0,            0,0,32'h00,0,  0,0,0,32'h00, 0,0,32'hDEADBEEF,32'h1000000C);
        vt[9]  = vt[8];
        vt[10] = vt[8];
        // Contention after core was last owner: debug first, burst of 4 each
        vt[11] = mk(1,0,32'h10,0, 1,0,32'h30,0, 0,1,0,32'h30, 0,0,32'hDEADBEEF,32'h1000000C);
        vt[12] = mk(1,0,32'h10,0, 1,0,32'h30,0, 0,1,0,32'h30, 0,1,32'hDEADBEEF,32'h1000000C);
        vt[13] = vt[12];
        vt[14] = vt[12];
        vt[15] = mk(1,0,32'h10,0, 1,0,32'h30,0, 1,0,0,32'h10, 0,1,32'hDEADBEEF,32'h1000000C);
        vt[16] = mk(1,0,32'h10,0, 1,0,32'h30,0, 1,0,0,32'h10, 1,0,32'hDEADBEEF,32'h1000000C);
        vt[17] = vt[16];
        vt[18] = vt[16];
        vt[19] = mk(0,0,32'h00,0, 0,0,32'h00,0, 0,0,0,32'h00, 1,0,32'hDEADBEEF,32'h1000000C);
        // Debug masked write (mask 4'h3), then debug read-after-write
        vt[20] = mk(0,0,32'h00,0,            1,1,32'h30,32'h5A5A5A5A, 0,1,1,32'h30, 0,0,32'hDEADBEEF,32'h1000000C);
        vt[21] = mk(1,1,32'h20,32'hFFFF0000, 1,0,32'h30,0,            0,1,0,32'h30, 0,0,32'hDEADBEEF,32'h1000000C);
        vt[22] = mk(0,0,32'h00,0,            0,0,32'h00,0,            0,0,0,32'h00, 0,1,32'hDEADBEEF,32'h10005A5A);

        c_mask = 4'hF; d_mask = 4'h3; c_load_ctrl = 3'd2; d_load_ctrl = 3'd5;
        c_we = 0; d_we = 0; c_addr = 32'h10; d_addr = 32'h30; c_wdata = 0; d_wdata = 0;

        // Reset held with both ports requesting: everything must stay quiet.
        rst = 1'b0; c_req = 1; d_req = 1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        chk("reset_c_gnt", {31'b0, c_gnt}, 0);
        chk("reset_d_gnt", {31'b0, d_gnt}, 0);
        chk("reset_mem_wr", {31'b0, mem_wr}, 0);
        chk("reset_rvalid", {30'b0, c_rvalid, d_rvalid}, 0);
        chk("reset_c_rdata", c_rdata, 0);
        chk("reset_d_rdata", d_rdata, 0);

        @(negedge clk);
        rst = 1'b1; c_req = 0; d_req = 0;

        for (int k = 0; k < 23; k++) begin
            if (k != 0) @(negedge clk);
            c_req = vt[k].cr; c_we = vt[k].cw; c_addr = vt[k].ca; c_wdata = vt[k].cd;
            d_req = vt[k].dr; d_we = vt[k].dw; d_addr = vt[k].da; d_wdata = vt[k].dd;
            #1;
            n_vec++;
            chk($sformatf("v%0d_c_gnt", k), {31'b0, c_gnt}, {31'b0, vt[k].gc});
            chk($sformatf("v%0d_d_gnt", k), {31'b0, d_gnt}, {31'b0, vt[k].gd});
            chk($sformatf("v%0d_mem_wr", k), {31'b0, mem_wr}, {31'b0, vt[k].wr});
            chk($sformatf("v%0d_mem_addr", k), mem_addr, vt[k].addr);
            chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vt[k].gd ? vt[k].dd : vt[k].cd);
            chk($sformatf("v%0d_mem_mask", k), {28'b0, mem_mask}, vt[k].gd ? 32'h3 : 32'hF);
            chk($sformatf("v%0d_mem_load", k), {29'b0, mem_load_ctrl}, vt[k].gd ? 32'd5 : 32'd2);
            chk($sformatf("v%0d_c_rvalid", k), {31'b0, c_rvalid}, {31'b0, vt[k].cv});
            chk($sformatf("v%0d_d_rvalid", k), {31'b0, d_rvalid}, {31'b0, vt[k].dv});
            chk($sformatf("v%0d_c_rdata", k), c_rdata, vt[k].crd);
            chk($sformatf("v%0d_d_rdata", k), d_rdata, vt[k].drd);
        end

        // Reset asserted during a granted debug read.
        @(negedge clk);
        c_req = 0; c_we = 0; d_req = 1; d_we = 0; d_addr = 32'h30;
        #1;
        n_vec++;
        chk("midrst_pre_d_gnt", {31'b0, d_gnt}, 1);
        #1 rst = 1'b0;
        #1;
        n_vec++;
        chk("midrst_c_gnt", {31'b0, c_gnt}, 0);
        chk("midrst_d_gnt", {31'b0, d_gnt}, 0);
        chk("midrst_mem_wr", {31'b0, mem_wr}, 0);
        chk("midrst_rvalid", {30'b0, c_rvalid, d_rvalid}, 0);
        chk("midrst_c_rdata", c_rdata, 0);
        chk("midrst_d_rdata", d_rdata, 0);

        @(negedge clk);
        c_req = 1; c_addr = 32'h10;
        #1;
        n_vec++;
        chk("inrst_gnt", {30'b0, c_gnt, d_gnt}, 0);
        chk("inrst_d_rvalid", {31'b0, d_rvalid}, 0);

        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        chk("postrst_c_gnt", {31'b0, c_gnt}, 1);
        chk("postrst_d_gnt", {31'b0, d_gnt}, 0);
        chk("postrst_d_rvalid", {31'b0, d_rvalid}, 0);

        @(negedge clk);
        #1;
        n_vec++;
        chk("postrst2_d_rvalid", {31'b0, d_rvalid}, 0);
        chk("postrst2_c_rvalid", {31'b0, c_rvalid}, 1);
        chk("postrst2_c_rdata", c_rdata, 32'hDEADBEEF);
        chk("postrst2_c_gnt", {31'b0, c_gnt}, 1);

        @(negedge clk);
        c_req = 0; d_req = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive grants to one port while the other port is requesting (legal range 1..15).
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-low reset; asserting it (low) SHALL reset all state immediately, independent of clk.
REQ-004 Core request ports SHALL be:
- c_req input 1: request.
- c_we input 1: write.
- c_addr input 32: address.
- c_wdata input 32: write data.
- c_mask input 4: byte mask.
- c_load_ctrl input 3: load type.
REQ-005 Debug/loader request ports SHALL be d_req, d_we, d_addr, d_wdata, d_mask and d_load_ctrl, identical in width and meaning to REQ-004.
REQ-006 Grant ports SHALL be c_gnt and d_gnt, output, 1 each: the request is accepted at the current rising edge.
REQ-007 Response ports SHALL be c_rvalid and d_rvalid (output, 1) and c_rdata and d_rdata (output, 32): registered read response.
REQ-008 Memory-side ports SHALL be:
- mem_wr output 1.
- mem_addr output 32.
- mem_wdata output 32.
- mem_mask output 4.
- mem_load_ctrl output 3.
- mem_rdata input 32: combinational read data for mem_addr.

Function
REQ-009 The block SHALL hold registered state {owner ∈ NONE/CORE/DBG, last ∈ CORE/DBG, cnt[3:0]}; all grant decisions SHALL be combinational from this state and the current c_req and d_req.
REQ-010 From NONE:
- a single requester SHALL be granted.
- with both requesting, the port not equal to last SHALL be granted.
REQ-011 From owner X with X requesting:
- X SHALL keep the grant unless the other port requests and cnt == MAX_BURST.
- in that case the other port SHALL be granted instead.
REQ-012 From owner X with X not requesting:
- the other port SHALL be granted if it requests.
- otherwise there SHALL be no grant.
REQ-013 At most one of c_gnt/d_gnt SHALL be high in any cycle; neither SHALL be high when its req is low.
REQ-014 On each edge the state SHALL update as follows:
- with a grant: owner <= granted port, last <= granted port.
- cnt <= cnt+1 (saturating at 15) if the same port was granted again, else cnt <= 1.
- with no grant: owner <= NONE and cnt <= 0; last is unchanged.
REQ-015 mem_addr, mem_wdata, mem_mask and mem_load_ctrl SHALL mux from the granted port, or from the core port when nothing is granted.
REQ-016 mem_wr SHALL equal the granted port's we AND its gnt; it SHALL be 0 when nothing is granted.
REQ-017 For a granted read (we=0), on the next edge:
- the granted port's rdata SHALL capture mem_rdata and its rvalid SHALL be 1 for exactly one cycle.
- the other port's rvalid SHALL be 0.
REQ-018 A granted write SHALL complete at the grant edge and SHALL produce no rvalid.
REQ-019 rdata SHALL hold its last captured value when rvalid is 0.
REQ-020 Read-after-write: a read granted the cycle after a write to the same address SHALL return the written data, because the memory writes on the grant edge.
REQ-021 Back-to-back reads by one port SHALL yield rvalid on consecutive cycles, with no bubble.

Reset
REQ-022 While rst is low, the state SHALL be owner=NONE, last=DBG, cnt=0.
REQ-023 While rst is low, c_gnt, d_gnt, mem_wr, c_rvalid and d_rvalid SHALL all be 0, and c_rdata and d_rdata SHALL be 32'h0.
REQ-024 Reset asserted mid-burst SHALL discard any pending read response; no rvalid SHALL appear after rst is released.
REQ-025 The first arbitration after reset with both ports requesting SHALL grant CORE.

Structure
REQ-026 Shared package dmem_arb_pkg SHALL hold the owner_e enum {OWN_NONE, OWN_CORE, OWN_DBG} and the constant DMEM_ARB_MAX_BURST_DEFAULT = 4.
REQ-027 The block SHALL be a single module with no sub-modules.
REQ-028 The state SHALL be one always_ff block with asynchronous negedge rst; grant and mux logic SHALL be one always_comb block.

Verification
REQ-029 Core only, reading addr 0x10 with mem_rdata=0xDEADBEEF -> c_gnt=1 in the same cycle; c_rvalid=1 and c_rdata=0xDEADBEEF at the next cycle.
REQ-030 Both ports requesting continuously after reset, MAX_BURST=4 -> grant pattern C,C,C,C,D,D,D,D,C...
REQ-031 Core writing 0xA5A5A5A5 to 0x20 with mask 4'hF, then reading 0x20 -> mem_wr=1 only in the write cycle; the read returns 0xA5A5A5A5 with c_rvalid one cycle later.
REQ-032 Debug read while core idle, then core requests in the next cycle while debug drops -> d_rvalid=1 and c_gnt=1 in the same cycle; no overlap on d_gnt.
REQ-033 rst pulled low during a granted debug read -> all outputs 0 immediately; d_rvalid stays 0 after release; first contended grant goes to the core.
REQ-034 Neither port requesting for 3 cycles -> mem_wr=0, no gnt, no rvalid; owner returns to NONE.
